hi_arbiter_rr: RTL and testbench
================================

// Module: hi_arbiter_rr
// PURPOSE
// - Parametrised N-master arbiter for the Host Interface (HI) device bus: N hosts share one di_* device port.
// - Registered grant FSM selects round-robin or fixed priority; hosts not granted see rdy=0 and zero data.
// - Replays a read_req that arrives before its host is granted; optional watchdog aborts hung transfers.
// - Sits between host PHYs (USB, SPI, debug) and the terminal decode/mux.
// PARAMETERS
// - NUM_HOSTS  2       number of masters, 2..16
// - RR         1       1 = round-robin starting at last_host+1; 0 = fixed priority, lowest index wins
// - TIMEOUT    0       idle cycles in ACTIVE before abort; 0 disables the watchdog
// - TMO_W      16      watchdog counter width; requires TIMEOUT < 2**TMO_W
// PORTS
// - ifclk                 in   1        HI clock
// - reset                 in   1        async, active-high
// - I_di_term_addr        in   16*N     per-host term addr, host k at [16k+15:16k] (same packing for all I_/O_ buses)
// - I_di_reg_addr         in   32*N     per-host reg addr
// - I_di_len              in   32*N     per-host transfer length
// - I_di_read_mode        in   N        per-host read transaction active
// - I_di_write_mode       in   N        per-host write transaction active
// - I_di_read_req         in   N        per-host read prefetch request pulse
// - I_di_read             in   N        per-host read strobe
// - I_di_write            in   N        per-host write strobe
// - I_di_reg_datai        in   32*N     per-host write data
// - O_di_read_rdy         out  N        read ready, granted host only
// - O_di_write_rdy        out  N        write ready, granted host only
// - O_di_reg_datao        out  32*N     read data, granted host only, else 0
// - O_di_transfer_status  out  16*N     status, granted host only, else 0
// - di_term_addr, di_reg_addr, di_len   out  16/32/32   muxed from the granted host
// - di_read_mode, di_write_mode         out  1          granted host's modes, gated by state==ACTIVE
// - di_read_req, di_read, di_write      out  1          muxed strobes; di_read_req also carries the replay pulse
// - di_reg_datai          out  32       muxed write data
// - di_read_rdy, di_write_rdy           in   1          device readies
// - di_reg_datao          in   32       device read data
// - di_transfer_status    in   16       device status
// - grant                 out  N        one-hot, the granted host while ACTIVE/FLUSH; 0 in IDLE
// - timeout_err           out  N        sticky per host, set on watchdog abort; cleared only by reset
// BEHAVIOUR
// - Reset: state=IDLE, host=0, last_host=N-1, pending=0, cnt=0, grant=0, timeout_err=0.
//   All di_* strobes/modes and O_* rdy lines are 0 during and after reset.
// - req[k] = I_di_read_mode[k] | I_di_write_mode[k].
// - IDLE: all downstream strobes/modes 0; all O_ rdy 0.
//   If |req, register host=pick(req,last_host) and enter ACTIVE next cycle (1-cycle grant latency).
// - ACTIVE: address/data/strobes pass combinationally for the granted host.
//   If pending[host] is set on ACTIVE entry, di_read_req pulses high for exactly the first ACTIVE cycle, then pending[host] clears.
//   Exit when req[host]==0: last_host<=host, go IDLE. This gives a minimum 1-cycle bus gap between owners.
// - Watchdog (TIMEOUT>0): cnt resets on entering ACTIVE and on any cycle with (di_read&di_read_rdy)|(di_write&di_write_rdy); otherwise increments.
//   When cnt==TIMEOUT: set timeout_err[host] and go FLUSH.
// - FLUSH: downstream modes/strobes forced 0; O_ rdy for host forced 0; grant held. Go IDLE once req[host]==0.
// - pending[k] is set by I_di_read_req[k] when k is not granted, or in the IDLE/arbitration cycle. A grant cycle coincident with read_req therefore still replays.
//   A read_req from the host in ACTIVE passes straight through and is not stored.
// - Simultaneous requests:
//   RR=1: first requester scanning last_host+1 .. wrapping modulo N.
//   RR=0: lowest index.
//   No host is granted twice in a row while another requests (RR=1).
// - reset asserted mid-transfer: immediate return to reset values; in-flight transfer is dropped with no replay.
// STRUCTURE
// - Package hi_arb_pkg: typedef enum {ARB_IDLE, ARB_ACTIVE, ARB_FLUSH} arb_state_t; HI width localparams (TERM_W=16, ADDR_W=32, DATA_W=32, STAT_W=16).
// - Sub-module hi_rr_pick: combinational rotating-priority encoder (req, last, rr_en) -> idx, valid.
// TESTING
// - Single host 0 write of 4 words, device rdy=1 -> grant=01 one cycle after write_mode; 4 di_write pulses; host 1 sees rdy=0.
// - RR=1, hosts 0 and 1 both assert read_mode continuously with 2-word reads -> grants alternate 0,1,0,1 with a 1-cycle IDLE gap each.
// - Host 1 pulses read_req while host 0 is ACTIVE -> when host 1 is granted, di_read_req is high exactly 1 cycle, on its first ACTIVE cycle.
// - TIMEOUT=8, device holds read_rdy=0 -> after 8 cycles timeout_err[0]=1, di_read_mode=0; IDLE once host drops read_mode.
// - RR=0, N=4, req=1010 -> host 1 granted; host 3 only after host 1 releases.
// - Assert reset mid-write -> next edge: grant=0, di_write_mode=0, pending=0.

Source files
------------

// File: rtl/hi_arb_pkg.sv
// Shared widths and FSM state encoding for the Host Interface device-bus arbiter.
package hi_arb_pkg;

  localparam int TERM_W = 16;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int STAT_W = 16;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_ACTIVE,
    ARB_FLUSH
  } arb_state_t;

endpackage

// File: rtl/hi_rr_pick.sv
// Rotating-priority encoder: first requester after 'last' (round-robin) or lowest index (fixed).
module hi_rr_pick #(
  parameter int N     = 2,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] last,
  input  logic             rr_en,
  output logic [IDX_W-1:0] idx,
  output logic             valid
);

  // Scan from farthest to nearest so the nearest requester overwrites and wins.
  always_comb begin
    idx   = '0;
    valid = |req;
    if (rr_en) begin
      for (int i = N; i >= 1; i--) begin
        if (|(req & (N'(1) << ((int'(last) + i) % N))))
          idx = IDX_W'((int'(last) + i) % N);
      end
    end else begin
      for (int i = N - 1; i >= 0; i--) begin
        if (req[i])
          idx = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/hi_arbiter_rr.sv
// N-host arbiter for the HI device bus: registered grant FSM, read_req replay and optional watchdog.
//   state      | meaning
//   ARB_IDLE   | no owner; downstream strobes/modes low; picks next host
//   ARB_ACTIVE | granted host drives the device port
//   ARB_FLUSH  | watchdog abort; grant held, bus quiet until host drops its mode
module hi_arbiter_rr
  import hi_arb_pkg::*;
#(
  parameter int NUM_HOSTS = 2,
  parameter int RR        = 1,
  parameter int TIMEOUT   = 0,
  parameter int TMO_W     = 16
) (
  input  logic                          ifclk,
  input  logic                          reset,
  input  logic [TERM_W*NUM_HOSTS-1:0]   I_di_term_addr,
  input  logic [ADDR_W*NUM_HOSTS-1:0]   I_di_reg_addr,
  input  logic [ADDR_W*NUM_HOSTS-1:0]   I_di_len,
  input  logic [NUM_HOSTS-1:0]          I_di_read_mode,
  input  logic [NUM_HOSTS-1:0]          I_di_write_mode,
  input  logic [NUM_HOSTS-1:0]          I_di_read_req,
  input  logic [NUM_HOSTS-1:0]          I_di_read,
  input  logic [NUM_HOSTS-1:0]          I_di_write,
  input  logic [DATA_W*NUM_HOSTS-1:0]   I_di_reg_datai,
  output logic [NUM_HOSTS-1:0]          O_di_read_rdy,
  output logic [NUM_HOSTS-1:0]          O_di_write_rdy,
  output logic [DATA_W*NUM_HOSTS-1:0]   O_di_reg_datao,
  output logic [STAT_W*NUM_HOSTS-1:0]   O_di_transfer_status,
  output logic [TERM_W-1:0]             di_term_addr,
  output logic [ADDR_W-1:0]             di_reg_addr,
  output logic [ADDR_W-1:0]             di_len,
  output logic                          di_read_mode,
  output logic                          di_write_mode,
  output logic                          di_read_req,
  output logic                          di_read,
  output logic                          di_write,
  output logic [DATA_W-1:0]             di_reg_datai,
  input  logic                          di_read_rdy,
  input  logic                          di_write_rdy,
  input  logic [DATA_W-1:0]             di_reg_datao,
  input  logic [STAT_W-1:0]             di_transfer_status,
  output logic [NUM_HOSTS-1:0]          grant,
  output logic [NUM_HOSTS-1:0]          timeout_err
);

  localparam int IDX_W = $clog2(NUM_HOSTS);

  arb_state_t           state;
  logic [IDX_W-1:0]     host;
  logic [IDX_W-1:0]     last_host;
  logic [IDX_W-1:0]     pick_idx;
  logic                 pick_valid;
  logic                 replay_q;
  logic                 active;
  logic                 hs;
  logic [NUM_HOSTS-1:0] req;
  logic [NUM_HOSTS-1:0] pending;
  logic [NUM_HOSTS-1:0] pend_acc;
  logic [TMO_W-1:0]     cnt;

  assign req    = I_di_read_mode | I_di_write_mode;
  assign active = (state == ARB_ACTIVE);
  assign hs     = (di_read & di_read_rdy) | (di_write & di_write_rdy);
  // grant is zero in IDLE, so a read_req in the arbitration cycle is still captured.
  assign pend_acc = pending | (I_di_read_req & ~grant);

  hi_rr_pick #(
    .N     (NUM_HOSTS),
    .IDX_W (IDX_W)
  ) u_pick (
    .req   (req),
    .last  (last_host),
    .rr_en (RR != 0),
    .idx   (pick_idx),
    .valid (pick_valid)
  );

  always_comb begin
    di_term_addr  = I_di_term_addr[int'(host)*TERM_W +: TERM_W];
    di_reg_addr   = I_di_reg_addr[int'(host)*ADDR_W +: ADDR_W];
    di_len        = I_di_len[int'(host)*ADDR_W +: ADDR_W];
    di_reg_datai  = I_di_reg_datai[int'(host)*DATA_W +: DATA_W];
    di_read_mode  = active & I_di_read_mode[host];
    di_write_mode = active & I_di_write_mode[host];
    di_read       = active & I_di_read[host];
    di_write      = active & I_di_write[host];
    di_read_req   = active & (I_di_read_req[host] | replay_q);
  end

  always_comb begin
    O_di_read_rdy        = '0;
    O_di_write_rdy       = '0;
    O_di_reg_datao       = '0;
    O_di_transfer_status = '0;
    for (int k = 0; k < NUM_HOSTS; k++) begin
      if (grant[k]) begin
        O_di_read_rdy[k]                         = active & di_read_rdy;
        O_di_write_rdy[k]                        = active & di_write_rdy;
        O_di_reg_datao[k*DATA_W +: DATA_W]       = di_reg_datao;
        O_di_transfer_status[k*STAT_W +: STAT_W] = di_transfer_status;
      end
    end
  end

  always_ff @(posedge ifclk or posedge reset) begin
    if (reset) begin
      state       <= ARB_IDLE;
      host        <= '0;
      last_host   <= IDX_W'(NUM_HOSTS - 1);
      pending     <= '0;
      cnt         <= '0;
      grant       <= '0;
      timeout_err <= '0;
      replay_q    <= 1'b0;
    end else begin
      pending  <= pend_acc;
      replay_q <= 1'b0;
      case (state)
        ARB_IDLE: begin
          cnt <= '0;
          if (pick_valid) begin
            host              <= pick_idx;
            grant             <= NUM_HOSTS'(1) << pick_idx;
            replay_q          <= pend_acc[pick_idx];
            pending[pick_idx] <= 1'b0;
            state             <= ARB_ACTIVE;
          end
        end
        ARB_ACTIVE: begin
          if (!req[host]) begin
            last_host <= host;
            grant     <= '0;
            state     <= ARB_IDLE;
          end else if (TIMEOUT > 0 && cnt == TMO_W'(TIMEOUT)) begin
            timeout_err[host] <= 1'b1;
            state             <= ARB_FLUSH;
          end else begin
            cnt <= hs ? '0 : cnt + 1'b1;
          end
        end
        ARB_FLUSH: begin
          if (!req[host]) begin
            last_host <= host;
            grant     <= '0;
            state     <= ARB_IDLE;
          end
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hi_arbiter_rr.sv
// Directed bench for hi_arbiter_rr: vector table for grant/strobe behaviour plus hand-written corner sequences.
module tb_hi_arbiter_rr;

  localparam int N = 4;

  logic ifclk = 1'b0;
  logic reset = 1'b1;
  always #5 ifclk = ~ifclk;

  logic [16*N-1:0] term_addr;
  logic [32*N-1:0] reg_addr, len_bus, datai;
  logic [N-1:0]    rmode, wmode, rreq, rd, wr;
  logic            dev_rrdy, dev_wrdy;
  logic [31:0]     dev_datao;
  logic [15:0]     dev_stat;

  logic [N-1:0]    o_rrdy, o_wrdy, grant, terr;
  logic [32*N-1:0] o_datao;
  logic [16*N-1:0] o_stat;
  logic [15:0]     d_term;
  logic [31:0]     d_addr, d_len, d_datai;
  logic            d_rmode, d_wmode, d_rreq, d_rd, d_wr;

  logic [N-1:0]    fp_rrdy, fp_wrdy, fp_grant, fp_terr;
  logic [32*N-1:0] fp_datao;
  logic [16*N-1:0] fp_stat;
  logic [15:0]     fp_term;
  logic [31:0]     fp_addr, fp_len, fp_datai;
  logic            fp_rmode, fp_wmode, fp_rreq, fp_rd, fp_wr;

  hi_arbiter_rr #(.NUM_HOSTS(N), .RR(1), .TIMEOUT(8), .TMO_W(16)) dut (
    .ifclk(ifclk), .reset(reset),
    .I_di_term_addr(term_addr), .I_di_reg_addr(reg_addr), .I_di_len(len_bus),
    .I_di_read_mode(rmode), .I_di_write_mode(wmode), .I_di_read_req(rreq),
    .I_di_read(rd), .I_di_write(wr), .I_di_reg_datai(datai),
    .O_di_read_rdy(o_rrdy), .O_di_write_rdy(o_wrdy), .O_di_reg_datao(o_datao),
    .O_di_transfer_status(o_stat),
    .di_term_addr(d_term), .di_reg_addr(d_addr), .di_len(d_len),
    .di_read_mode(d_rmode), .di_write_mode(d_wmode), .di_read_req(d_rreq),
    .di_read(d_rd), .di_write(d_wr), .di_reg_datai(d_datai),
    .di_read_rdy(dev_rrdy), .di_write_rdy(dev_wrdy), .di_reg_datao(dev_datao),
    .di_transfer_status(dev_stat), .grant(grant), .timeout_err(terr)
  );

  hi_arbiter_rr #(.NUM_HOSTS(N), .RR(0), .TIMEOUT(0), .TMO_W(16)) dut_fp (
    .ifclk(ifclk), .reset(reset),
    .I_di_term_addr(term_addr), .I_di_reg_addr(reg_addr), .I_di_len(len_bus),
    .I_di_read_mode(rmode), .I_di_write_mode(wmode), .I_di_read_req(rreq),
    .I_di_read(rd), .I_di_write(wr), .I_di_reg_datai(datai),
    .O_di_read_rdy(fp_rrdy), .O_di_write_rdy(fp_wrdy), .O_di_reg_datao(fp_datao),
    .O_di_transfer_status(fp_stat),
    .di_term_addr(fp_term), .di_reg_addr(fp_addr), .di_len(fp_len),
    .di_read_mode(fp_rmode), .di_write_mode(fp_wmode), .di_read_req(fp_rreq),
    .di_read(fp_rd), .di_write(fp_wr), .di_reg_datai(fp_datai),
    .di_read_rdy(dev_rrdy), .di_write_rdy(dev_wrdy), .di_reg_datao(dev_datao),
    .di_transfer_status(dev_stat), .grant(fp_grant), .timeout_err(fp_terr)
  );

  typedef struct packed {
    logic       rst;
    logic [3:0] rm, wm, rq, rdv, wrv, eg;
    logic [4:0] e;   // expected {read_mode, write_mode, read_req, read, write}
  } vec_t;

  vec_t tbl[$];
  int   vec_cnt = 0;
  int   miscompares = 0;

  function automatic vec_t mk(input logic r, input logic [3:0] rm_i, input logic [3:0] wm_i,
                              input logic [3:0] rq_i, input logic [3:0] rd_i, input logic [3:0] wr_i,
                              input logic [3:0] eg_i, input logic [4:0] e_i);
    vec_t v;
    v.rst = r; v.rm = rm_i; v.wm = wm_i; v.rq = rq_i; v.rdv = rd_i; v.wrv = wr_i;
    v.eg = eg_i; v.e = e_i;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    rmode = '0; wmode = '0; rreq = '0; rd = '0; wr = '0;
    dev_rrdy = 1'b1; dev_wrdy = 1'b1;
  endtask

  task automatic reset_pulse();
    reset = 1'b1;
    idle_inputs();
    @(posedge ifclk); #1;
    reset = 1'b0;
  endtask

  task automatic apply_vec(input int n, input vec_t v);
    logic [32*N-1:0] exp_datao;
    logic [16*N-1:0] exp_stat;
    logic [4:0]      got;
    int              gi;
    reset = v.rst;
    rmode = v.rm; wmode = v.wm; rreq = v.rq; rd = v.rdv; wr = v.wrv;
    dev_rrdy = 1'b1; dev_wrdy = 1'b1;
    @(negedge ifclk);
    exp_datao = '0; exp_stat = '0; gi = 0;
    for (int k = 0; k < N; k++) begin
      if (v.eg[k]) begin
        exp_datao[k*32 +: 32] = dev_datao;
        exp_stat[k*16 +: 16]  = dev_stat;
        gi = k;
      end
    end
    got = {d_rmode, d_wmode, d_rreq, d_rd, d_wr};
    vec_cnt++;
    if (grant !== v.eg || got !== v.e || o_rrdy !== v.eg || o_wrdy !== v.eg ||
        o_datao !== exp_datao || o_stat !== exp_stat) begin
      miscompares++;
      $display("FAIL vec[%0d]: got grant=%b strobes=%b rrdy=%b wrdy=%b, want grant=%b strobes=%b rrdy=%b wrdy=%b (datao/stat ok=%0d)",
               n, grant, got, o_rrdy, o_wrdy, v.eg, v.e, v.eg, v.eg,
               (o_datao === exp_datao) && (o_stat === exp_stat));
    end
    if (v.eg != 0) begin
      vec_cnt++;
      if (d_term !== term_addr[gi*16 +: 16] || d_addr !== 32'hA000_0000 + gi ||
          d_len !== 32'h0000_0100 + gi || d_datai !== 32'hD000_0000 + gi) begin
        miscompares++;
        $display("FAIL vec[%0d] mux: got term=%h addr=%h len=%h datai=%h for host %0d",
                 n, d_term, d_addr, d_len, d_datai, gi);
      end
    end
    @(posedge ifclk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, want finish");
    $fatal(1, "global timeout");
  end

  initial begin
    int err_at;
    for (int k = 0; k < N; k++) begin
      term_addr[k*16 +: 16] = 16'h7000 + 16'(k);
      reg_addr[k*32 +: 32]  = 32'hA000_0000 + 32'(k);
      len_bus[k*32 +: 32]   = 32'h0000_0100 + 32'(k);
      datai[k*32 +: 32]     = 32'hD000_0000 + 32'(k);
    end
    dev_datao = 32'h1234_5678;
    dev_stat  = 16'h5A3C;
    idle_inputs();

    // single host 0 write of 4 words
    tbl.push_back(mk(1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 5'b00000));
    tbl.push_back(mk(0, 4'h0, 4'h1, 4'h0, 4'h0, 4'h0, 4'h0, 5'b00000));
    for (int i = 0; i < 4; i++)
      tbl.push_back(mk(0, 4'h0, 4'h1, 4'h0, 4'h0, 4'h1, 4'h1, 5'b01001));
    tbl.push_back(mk(0, 4'h0, 4'h1, 4'h0, 4'h0, 4'h0, 4'h1, 5'b01000));
    tbl.push_back(mk(0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h1, 5'b00000));
    tbl.push_back(mk(0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 5'b00000));
    // round-robin alternation between hosts 0 and 1
    tbl.push_back(mk(1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 5'b00000));
    tbl.push_back(mk(0, 4'h3, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 5'b00000));
    tbl.push_back(mk(0, 4'h3, 4'h0, 4'h0, 4'h1, 4'h0, 4'h1, 5'b10010));
    tbl.push_back(mk(0, 4'h3, 4'h0, 4'h0, 4'h1, 4'h0, 4'h1, 5'b10010));
    tbl.push_back(mk(0, 4'h2, 4'h0, 4'h0, 4'h0, 4'h0, 4'h1, 5'b00000));
    tbl.push_back(mk(0, 4'h3, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 5'b00000));
    tbl.push_back(mk(0, 4'h3, 4'h0, 4'h0, 4'h2, 4'h0, 4'h2, 5'b10010));
    tbl.push_back(mk(0, 4'h3, 4'h0, 4'h0, 4'h2, 4'h0, 4'h2, 5'b10010));
    tbl.push_back(mk(0, 4'h1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h2, 5'b00000));
    tbl.push_back(mk(0, 4'h3, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 5'b00000));
    tbl.push_back(mk(0, 4'h3, 4'h0, 4'h0, 4'h1, 4'h0, 4'h1, 5'b10010));
    tbl.push_back(mk(0, 4'h2, 4'h0, 4'h0, 4'h0, 4'h0, 4'h1, 5'b00000));
    tbl.push_back(mk(0, 4'h3, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 5'b00000));
    tbl.push_back(mk(0, 4'h3, 4'h0, 4'h0, 4'h0, 4'h0, 4'h2, 5'b10000));
    tbl.push_back(mk(0, 4'h1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h2, 5'b00000));
    tbl.push_back(mk(0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 5'b00000));
    // read_req replay, coincident-grant replay and pass-through without storage
    tbl.push_back(mk(1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 5'b00000));
    tbl.push_back(mk(0, 4'h1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 5'b00000));
    tbl.push_back(mk(0, 4'h1, 4'h0, 4'h2, 4'h0, 4'h0, 4'h1, 5'b10000));
    tbl.push_back(mk(0, 4'h3, 4'h0, 4'h0, 4'h0, 4'h0, 4'h1, 5'b10000));
    tbl.push_back(mk(0, 4'h2, 4'h0, 4'h0, 4'h0, 4'h0, 4'h1, 5'b00000));
    tbl.push_back(mk(0, 4'h2, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 5'b00000));
    tbl.push_back(mk(0, 4'h2, 4'h0, 4'h0, 4'h0, 4'h0, 4'h2, 5'b10100));
    tbl.push_back(mk(0, 4'h2, 4'h0, 4'h0, 4'h0, 4'h0, 4'h2, 5'b10000));
    tbl.push_back(mk(0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h2, 5'b00000));
    tbl.push_back(mk(0, 4'h1, 4'h0, 4'h1, 4'h0, 4'h0, 4'h0, 5'b00000));
    tbl.push_back(mk(0, 4'h1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h1, 5'b10100));
    tbl.push_back(mk(0, 4'h1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h1, 5'b10000));
    tbl.push_back(mk(0, 4'h1, 4'h0, 4'h1, 4'h0, 4'h0, 4'h1, 5'b10100));
    tbl.push_back(mk(0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h1, 5'b00000));
    tbl.push_back(mk(0, 4'h1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 5'b00000));
    tbl.push_back(mk(0, 4'h1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h1, 5'b10000));
    tbl.push_back(mk(0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h1, 5'b00000));
    tbl.push_back(mk(0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 5'b00000));

    @(posedge ifclk); #1;
    chk("reset_timeout_err", 64'(terr), 64'h0);
    for (int i = 0; i < tbl.size(); i++)
      apply_vec(i, tbl[i]);

    // watchdog: device never ready, host 0 keeps strobing
    reset_pulse();
    dev_rrdy = 1'b0; rmode = 4'h1; rd = 4'h1;
    @(posedge ifclk); #1;
    err_at = 0;
    for (int j = 1; j <= 14; j++) begin
      @(negedge ifclk);
      if (err_at == 0 && terr[0]) err_at = j;
      @(posedge ifclk); #1;
    end
    vec_cnt++;
    if (!(err_at >= 9 && err_at <= 10)) begin
      miscompares++;
      $display("FAIL tmo_err_cycle: got err in ACTIVE cycle %0d want 9..10", err_at);
    end
    dev_rrdy = 1'b1;
    @(negedge ifclk);
    chk("flush_read_mode", 64'(d_rmode), 64'h0);
    chk("flush_read", 64'(d_rd), 64'h0);
    chk("flush_o_rrdy", 64'(o_rrdy), 64'h0);
    chk("flush_grant", 64'(grant), 64'h1);
    @(posedge ifclk); #1;
    rmode = 4'h0; rd = 4'h0;
    @(posedge ifclk); #1;
    @(negedge ifclk);
    chk("flush_to_idle_grant", 64'(grant), 64'h0);
    chk("timeout_err_sticky", 64'(terr), 64'h1);
    @(posedge ifclk); #1;

    // fixed priority: req=1010 -> host 1, then host 3
    reset_pulse();
    rmode = 4'b1010;
    @(negedge ifclk);
    chk("fp_idle_grant", 64'(fp_grant), 64'h0);
    @(posedge ifclk); #1;
    @(negedge ifclk);
    chk("fp_grant_h1", 64'(fp_grant), 64'h2);
    @(posedge ifclk); #1;
    @(negedge ifclk);
    chk("fp_hold_h1", 64'(fp_grant), 64'h2);
    @(posedge ifclk); #1;
    rmode = 4'b1000;
    @(negedge ifclk);
    chk("fp_release_h1", 64'(fp_grant), 64'h2);
    @(posedge ifclk); #1;
    @(negedge ifclk);
    chk("fp_gap", 64'(fp_grant), 64'h0);
    @(posedge ifclk); #1;
    @(negedge ifclk);
    chk("fp_grant_h3", 64'(fp_grant), 64'h8);
    @(posedge ifclk); #1;

    // reset mid-write drops the transfer and any pending replay
    reset_pulse();
    wmode = 4'h1; wr = 4'h1;
    @(posedge ifclk); #1;
    rreq = 4'h4;
    @(negedge ifclk);
    chk("mid_write_grant", 64'(grant), 64'h1);
    chk("mid_write_mode", 64'(d_wmode), 64'h1);
    #2;
    reset = 1'b1;
    #1;
    chk("async_rst_grant", 64'(grant), 64'h0);
    chk("async_rst_strobes", 64'({d_wmode, d_wr, o_wrdy}), 64'h0);
    @(posedge ifclk); #1;
    chk("rst_edge_grant", 64'(grant), 64'h0);
    reset = 1'b0;
    wmode = 4'h0; wr = 4'h0; rreq = 4'h0; rmode = 4'h4;
    @(negedge ifclk);
    chk("post_rst_idle", 64'(grant), 64'h0);
    @(posedge ifclk); #1;
    @(negedge ifclk);
    chk("post_rst_grant_h2", 64'(grant), 64'h4);
    chk("post_rst_no_replay", 64'(d_rreq), 64'h0);
    @(posedge ifclk); #1;
    idle_inputs();
    @(posedge ifclk); #1;

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscompares);
    $finish;
  end

endmodule
